// File: rtl/serial_frame_tx.sv
// serial_frame_tx: shifts one left/right word pair out MSB-first, framed by OutReady.
// Define SERIAL_FRAME_TX_OVERRUN_EN to add the sticky overrun flag for loads dropped during SHIFT.
module serial_frame_tx #(
    parameter int DATA_W = 40
) (
    input  logic              SCLK,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] dataL,
    input  logic [DATA_W-1:0] dataR,
    output logic              OutReady,
    output logic              OutputL,
    output logic              OutputR,
    output logic              done,
    output logic              overrun
);
    localparam int CW = $clog2(DATA_W);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] shift_l, shift_r, shift_l_nx, shift_r_nx;
    logic [CW-1:0]     bitcnt, bitcnt_nx;
    logic              done_r, done_nx;

    always_ff @(posedge SCLK or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shift_l <= '0;
            shift_r <= '0;
            bitcnt  <= '0;
            done_r  <= 1'b0;
        end else begin
            state   <= state_nx;
            shift_l <= shift_l_nx;
            shift_r <= shift_r_nx;
            bitcnt  <= bitcnt_nx;
            done_r  <= done_nx;
        end
    end

    // The last shift parks bitcnt at 0 instead of letting it wrap.
    always_comb begin
        state_nx   = state;
        shift_l_nx = shift_l;
        shift_r_nx = shift_r;
        bitcnt_nx  = bitcnt;
        done_nx    = 1'b0;
        if (clear) begin
            state_nx   = IDLE;
            shift_l_nx = '0;
            shift_r_nx = '0;
            bitcnt_nx  = '0;
        end else if (state == IDLE) begin
            if (load) begin
                state_nx   = SHIFT;
                shift_l_nx = dataL;
                shift_r_nx = dataR;
                bitcnt_nx  = CW'(DATA_W - 1);
            end
        end else begin
            shift_l_nx = {shift_l[DATA_W-2:0], 1'b0};
            shift_r_nx = {shift_r[DATA_W-2:0], 1'b0};
            bitcnt_nx  = (bitcnt == '0) ? '0 : bitcnt - CW'(1);
            state_nx   = (bitcnt == '0) ? IDLE : SHIFT;
            done_nx    = (bitcnt == '0);
        end
    end

    assign OutReady = (state == SHIFT);
    assign OutputL  = OutReady & shift_l[DATA_W-1];
    assign OutputR  = OutReady & shift_r[DATA_W-1];
    assign done     = done_r;

`ifdef SERIAL_FRAME_TX_OVERRUN_EN
    logic overrun_r;

    always_ff @(posedge SCLK or negedge rst_n) begin
        if (!rst_n)
            overrun_r <= 1'b0;
        else if (clear)
            overrun_r <= 1'b0;
        else if (load && state == SHIFT)
            overrun_r <= 1'b1;
    end

    assign overrun = overrun_r;
`else
    assign overrun = 1'b0;
`endif
endmodule
